// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter over a DATA/DATA_READY/IDLE handshake.
// Optional frame-sync header insertion before tagged bytes: define UART_TX_FIFO_SYNC_EN.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [7:0]  SYNC0      = 8'hFF,
   parameter logic [7:0]  SYNC1      = 8'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] WR_DATA,
   input  logic       WR_EN,
   input  logic       WR_SOF,
   output logic       FULL,
   output logic       EMPTY,
   output logic       OVERFLOW,
   output logic [7:0] TX_DATA,
   output logic       TX_READY,
   input  logic       TX_IDLE
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef UART_TX_FIFO_SYNC_EN
   localparam int unsigned WIDTH = 9;
`else
   localparam int unsigned WIDTH = 8;
`endif

   typedef enum logic [1:0] {S_RUN, S_HDR0, S_HDR1, S_PAY} state_t;

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  wr_ok, pop, head_sof;
   logic [7:0]            head;
   logic [WIDTH-1:0]      wr_word;

   assign FULL  = (count == FULL_COUNT);
   assign EMPTY = (count == '0);
   // Drop decision uses the registered count, so a same-cycle pop never frees a slot.
   assign wr_ok = WR_EN & ~FULL;
   assign head  = mem[rd_ptr][7:0];

`ifdef UART_TX_FIFO_SYNC_EN
   assign head_sof = mem[rd_ptr][8];
   assign wr_word  = {WR_SOF, WR_DATA};
`else
   logic sof_unused;
   assign sof_unused = WR_SOF;
   assign head_sof   = 1'b0;
   assign wr_word    = WR_DATA;
`endif

   always_ff @(posedge CLK) begin
      if (wr_ok) mem[wr_ptr] <= wr_word;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_RUN;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !pop)      count <= count + 1'b1;
         else if (!wr_ok && pop) count <= count - 1'b1;
         if (WR_EN && FULL) OVERFLOW <= 1'b1;
      end
   end

   // Tagged head is held in the FIFO through both header bytes, so S_PAY always has data.
   always_comb begin
      state_nxt = state;
      TX_READY  = 1'b0;
      TX_DATA   = head;
      pop       = 1'b0;
      unique case (state)
         S_RUN: begin
            if (!EMPTY) begin
               if (head_sof) begin
                  state_nxt = S_HDR0;
               end else begin
                  TX_READY = 1'b1;
                  pop      = TX_IDLE;
               end
            end
         end
         S_HDR0: begin
            TX_READY = 1'b1;
            TX_DATA  = SYNC0;
            if (TX_IDLE) state_nxt = S_HDR1;
         end
         S_HDR1: begin
            TX_READY = 1'b1;
            TX_DATA  = SYNC1;
            if (TX_IDLE) state_nxt = S_PAY;
         end
         S_PAY: begin
            TX_READY = 1'b1;
            pop      = TX_IDLE;
            if (TX_IDLE) state_nxt = S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences,
// and randomized traffic against a stream-level reference model.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;
`ifdef UART_TX_FIFO_SYNC_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST, WR_EN, WR_SOF, TX_IDLE;
   logic [7:0] WR_DATA;
   logic       FULL, EMPTY, OVERFLOW, TX_READY;
   logic [7:0] TX_DATA;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   logic [7:0] got [$];

   typedef struct {
      bit       wr_en;
      bit [7:0] wr_data;
      bit       tx_idle;
      bit       exp_ready;
      bit [7:0] exp_data;
      bit       exp_full;
      bit       exp_empty;
      bit       exp_ovf;
   } vec_t;

   typedef struct packed {
      logic [7:0] b;
      logic       pay;
   } ent_t;

   always #5 CLK = ~CLK;

   uart_tx_fifo #(.DEPTH_LOG2(4), .SYNC0(8'hFF), .SYNC1(8'h00)) dut (
      .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .WR_SOF(WR_SOF),
      .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW), .TX_DATA(TX_DATA),
      .TX_READY(TX_READY), .TX_IDLE(TX_IDLE)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      RST = 1'b1; WR_EN = 1'b0; WR_SOF = 1'b0; WR_DATA = '0; TX_IDLE = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic drain(input string name, input int unsigned budget);
      int unsigned c = 0;
      got.delete();
      WR_EN = 1'b0; WR_SOF = 1'b0; TX_IDLE = 1'b1;
      while (!(EMPTY && !TX_READY) && c < budget) begin
         if (TX_READY) got.push_back(TX_DATA);
         @(negedge CLK);
         c++;
      end
      chk({name, " drain in budget"}, 32'(c < budget), 32'd1);
      TX_IDLE = 1'b0;
   endtask

   task automatic cmp_q(input string name, input logic [7:0] exp[$]);
      chk({name, " length"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s byte%0d", name, i), got[i], exp[i]);
   endtask

   task automatic write_byte(input logic [7:0] d, input logic sof);
      WR_EN = 1'b1; WR_DATA = d; WR_SOF = sof;
      @(negedge CLK);
      WR_EN = 1'b0; WR_SOF = 1'b0;
   endtask

   initial begin : main
      vec_t       vecs [5];
      logic [7:0] exp [$];
      ent_t       strm [$];
      ent_t       e;
      int         cnt;
      bit         ovf, acc, full_now, prev_ready, prev_acc;
      logic [7:0] prev_data;

      vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

      // reset state
      do_reset();
      #1;
      chk("reset FULL", FULL, 0);
      chk("reset EMPTY", EMPTY, 1);
      chk("reset TX_READY", TX_READY, 0);
      chk("reset OVERFLOW", OVERFLOW, 0);
      @(negedge CLK);

      // three back-to-back bytes with transmitter idle
      for (int i = 0; i < 5; i++) begin
         WR_EN = vecs[i].wr_en; WR_DATA = vecs[i].wr_data; WR_SOF = 1'b0;
         TX_IDLE = vecs[i].tx_idle;
         #1;
         chk($sformatf("vec%0d TX_READY", i), TX_READY, vecs[i].exp_ready);
         if (vecs[i].exp_ready) chk($sformatf("vec%0d TX_DATA", i), TX_DATA, vecs[i].exp_data);
         chk($sformatf("vec%0d FULL", i), FULL, vecs[i].exp_full);
         chk($sformatf("vec%0d EMPTY", i), EMPTY, vecs[i].exp_empty);
         chk($sformatf("vec%0d OVERFLOW", i), OVERFLOW, vecs[i].exp_ovf);
         @(negedge CLK);
      end
      WR_EN = 1'b0; TX_IDLE = 1'b0;

      // fill to full, 17th write dropped
      do_reset();
      for (int i = 0; i < 17; i++) begin
         write_byte(8'(i), 1'b0);
         if (i == 14) chk("fill FULL after 15", FULL, 0);
         if (i == 15) begin
            chk("fill FULL after 16", FULL, 1);
            chk("fill OVERFLOW after 16", OVERFLOW, 0);
         end
      end
      chk("fill OVERFLOW after 17", OVERFLOW, 1);
      chk("fill FULL after 17", FULL, 1);
      drain("fill", 100);
      exp.delete();
      for (int i = 0; i < 16; i++) exp.push_back(8'(i));
      cmp_q("fill", exp);
      chk("fill OVERFLOW sticky", OVERFLOW, 1);
      chk("fill EMPTY after drain", EMPTY, 1);

      // write while full coinciding with a pop is still dropped
      do_reset();
      for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i), 1'b0);
      chk("popfull FULL", FULL, 1);
      WR_EN = 1'b1; WR_DATA = 8'hEE; TX_IDLE = 1'b1;
      #1;
      chk("popfull TX_READY", TX_READY, 1);
      chk("popfull TX_DATA", TX_DATA, 8'h80);
      @(negedge CLK);
      chk("popfull FULL after pop", FULL, 0);
      chk("popfull OVERFLOW", OVERFLOW, 1);
      WR_DATA = 8'h77; TX_IDLE = 1'b0;
      @(negedge CLK);
      WR_EN = 1'b0;
      chk("popfull FULL refilled", FULL, 1);
      drain("popfull", 100);
      exp.delete();
      for (int i = 1; i < 16; i++) exp.push_back(8'h80 + 8'(i));
      exp.push_back(8'h77);
      cmp_q("popfull", exp);

      // tagged byte then untagged byte
      do_reset();
      write_byte(8'hAB, 1'b1);
      write_byte(8'hCD, 1'b0);
      drain("sof", 100);
      exp.delete();
      if (SYNC_ON) begin exp.push_back(8'hFF); exp.push_back(8'h00); end
      exp.push_back(8'hAB);
      exp.push_back(8'hCD);
      cmp_q("sof", exp);

      // reset while a header is in flight
      do_reset();
      write_byte(8'hAB, 1'b1);
      @(negedge CLK);
`ifdef UART_TX_FIFO_SYNC_EN
      chk("hdr0 TX_READY", TX_READY, 1);
      chk("hdr0 TX_DATA", TX_DATA, 8'hFF);
`endif
      TX_IDLE = 1'b1;
      @(negedge CLK);
      TX_IDLE = 1'b0;
`ifdef UART_TX_FIFO_SYNC_EN
      chk("hdr1 TX_READY", TX_READY, 1);
      chk("hdr1 TX_DATA", TX_DATA, 8'h00);
`endif
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("midrst TX_READY", TX_READY, 0);
      chk("midrst EMPTY", EMPTY, 1);
      chk("midrst OVERFLOW", OVERFLOW, 0);
      @(negedge CLK);
      write_byte(8'h5A, 1'b0);
      drain("midrst", 100);
      exp.delete();
      exp.push_back(8'h5A);
      cmp_q("midrst", exp);

      // randomized traffic: light load (wraps pointers), then heavy load (overflow)
      do_reset();
      cnt = 0; ovf = 1'b0; strm.delete();
      prev_ready = 1'b0; prev_acc = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         chk("rnd FULL", FULL, 32'(cnt == DEPTH));
         chk("rnd EMPTY", EMPTY, 32'(cnt == 0));
         chk("rnd OVERFLOW", OVERFLOW, 32'(ovf));
`ifndef UART_TX_FIFO_SYNC_EN
         chk("rnd TX_READY", TX_READY, 32'(cnt != 0));
`endif
         if (TX_READY) begin
            chk("rnd offer has data", 32'(strm.size() != 0), 32'd1);
            if (strm.size() != 0) chk("rnd TX_DATA", TX_DATA, strm[0].b);
         end
         if (prev_ready && !prev_acc) begin
            chk("rnd hold TX_READY", TX_READY, 1);
            chk("rnd hold TX_DATA", TX_DATA, prev_data);
         end
         if (cyc < 400) begin
            WR_EN   = ($urandom_range(0, 1) == 1);
            TX_IDLE = ($urandom_range(0, 3) != 0);
         end else begin
            WR_EN   = ($urandom_range(0, 3) != 0);
            TX_IDLE = ($urandom_range(0, 3) == 0);
         end
         WR_DATA = 8'($urandom);
         WR_SOF  = ($urandom_range(0, 3) == 0);
         acc = TX_READY & TX_IDLE;
         full_now = (cnt == DEPTH);
         if (acc && strm.size() != 0) begin
            e = strm.pop_front();
            if (e.pay) cnt--;
         end
         if (WR_EN) begin
            if (full_now) ovf = 1'b1;
            else begin
               if (SYNC_ON && WR_SOF) begin
                  strm.push_back('{b: 8'hFF, pay: 1'b0});
                  strm.push_back('{b: 8'h00, pay: 1'b0});
               end
               strm.push_back('{b: WR_DATA, pay: 1'b1});
               cnt++;
            end
         end
         prev_ready = TX_READY; prev_data = TX_DATA; prev_acc = acc;
         @(negedge CLK);
      end
      drain("rnd tail", 200);
      exp.delete();
      foreach (strm[i]) exp.push_back(strm[i].b);
      cmp_q("rnd tail", exp);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
